// File: rtl/song_recorder.sv
// Song recorder: turns note/tempo strobes into playback-format song words and
// streams them through a small FIFO to RAM, closing each recording with a terminator.
module song_recorder #(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          MAX_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REC_START,
  input  logic        REC_STOP,
  input  logic        NOTE_STB,
  input  logic [1:0]  MODE_IN,
  input  logic [5:0]  TONE_IN,
  input  logic [3:0]  NOTE_IN,
  input  logic        BPM_STB,
  input  logic [7:0]  BPM_IN,
  output logic        WR_REQ,
  output logic [22:0] WR_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        WR_ACK,
  output logic        RECORDING,
  output logic        FULL,
  output logic        DROP,
  output logic [15:0] LEN
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] CAP_C   = 32'(MAX_WORDS - 1);
  localparam logic [15:0] TERM_WORD = 16'hC000;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] REC   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] TERM  = 3'd4;

  function automatic logic [15:0] noteWord(input logic [1:0] mode, input logic [5:0] tone,
                                           input logic [3:0] dur);
    logic [1:0] m;
    m = (mode == 2'b11) ? 2'b00 : mode;
    return {m, tone, 4'b0000, dur};
  endfunction

  function automatic logic [15:0] bpmWord(input logic [7:0] bpm);
    return {2'b11, 6'b000000, (bpm == 8'd0) ? 8'd1 : bpm};
  endfunction

  logic [2:0]   state_r;
  logic [15:0]  fifoMem_r [FIFO_DEPTH];
  logic [AW-1:0] rdPtr_r;
  logic [AW-1:0] wrPtr_r;
  logic [AW:0]  fifoCnt_r;
  logic [31:0]  enqCnt_r;
  logic         wrReq_r;
  logic [22:0]  wrAddr_r;
  logic [15:0]  wrData_r;
  logic [15:0]  len_r;
  logic         full_r;
  logic         drop_r;

  logic [2:0]   stateNext_s;
  logic         enq_s;
  logic [15:0]  enqWord_s;
  logic         setDrop_s;
  logic         setFull_s;
  logic         start_s;
  logic         strobe_s;
  logic         ack_s;
  logic         pop_s;
  logic         load_s;
  logic [15:0]  loadWord_s;
  logic         fifoRoom_s;
  logic         capOk_s;

  assign strobe_s   = NOTE_STB | BPM_STB;
  assign ack_s      = wrReq_r & WR_ACK;
  // The head word stays queued until accepted, so pending words never exceed FIFO_DEPTH.
  assign pop_s      = ack_s & (state_r != TERM);
  assign fifoRoom_s = (fifoCnt_r != DEPTH_C) | pop_s;
  assign capOk_s    = (enqCnt_r < CAP_C);
  assign load_s     = ~wrReq_r & ((fifoCnt_r != {(AW + 1){1'b0}}) | (state_r == TERM));
  assign loadWord_s = (fifoCnt_r != {(AW + 1){1'b0}}) ? fifoMem_r[rdPtr_r] : TERM_WORD;

  // Next state and enqueue decision for the current cycle's commands.
  always_comb begin
    stateNext_s = state_r;
    enq_s       = 1'b0;
    enqWord_s   = 16'h0000;
    setDrop_s   = 1'b0;
    setFull_s   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (REC_START) begin
          start_s   = 1'b1;
          enq_s     = 1'b1;
          enqWord_s = bpmWord(BPM_IN);
          if (CAP_C <= 32'd1) begin
            setFull_s   = 1'b1;
            stateNext_s = DRAIN;
          end else begin
            stateNext_s = HDR;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      HDR, REC: begin
        if ((state_r == REC) && REC_STOP) begin
          stateNext_s = DRAIN;
        end else begin
          stateNext_s = REC;
          if (strobe_s) begin
            // Tempo wins a same-cycle collision; the note is lost.
            enqWord_s = BPM_STB ? bpmWord(BPM_IN) : noteWord(MODE_IN, TONE_IN, NOTE_IN);
            if (!capOk_s) begin
              enq_s = 1'b0;
            end else if (!fifoRoom_s) begin
              setDrop_s = 1'b1;
            end else begin
              enq_s     = 1'b1;
              setDrop_s = NOTE_STB & BPM_STB;
              if ((enqCnt_r + 32'd1) == CAP_C) begin
                setFull_s   = 1'b1;
                stateNext_s = DRAIN;
              end else begin
                stateNext_s = REC;
              end
            end
          end else begin
            enq_s = 1'b0;
          end
        end
      end
      DRAIN: begin
        if ((fifoCnt_r == {(AW + 1){1'b0}}) && !wrReq_r) begin
          stateNext_s = TERM;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      TERM: begin
        if (ack_s) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = TERM;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Pending-word FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdPtr_r   <= {AW{1'b0}};
      wrPtr_r   <= {AW{1'b0}};
      fifoCnt_r <= {(AW + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem_r[i] <= 16'h0000;
      end
    end else begin
      if (enq_s) begin
        fifoMem_r[wrPtr_r] <= enqWord_s;
        wrPtr_r            <= wrPtr_r + AW'(1);
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + AW'(1);
      end
      case ({enq_s, pop_s})
        2'b10:   fifoCnt_r <= fifoCnt_r + (AW + 1)'(1);
        2'b01:   fifoCnt_r <= fifoCnt_r - (AW + 1)'(1);
        default: fifoCnt_r <= fifoCnt_r;
      endcase
    end
  end

  // FSM, status flags and the RAM write handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= IDLE;
      enqCnt_r <= 32'd0;
      wrReq_r  <= 1'b0;
      wrAddr_r <= BASE_ADDR;
      wrData_r <= 16'h0000;
      len_r    <= 16'h0000;
      full_r   <= 1'b0;
      drop_r   <= 1'b0;
    end else begin
      state_r <= stateNext_s;

      if (start_s) begin
        enqCnt_r <= 32'd1;
        full_r   <= setFull_s;
        drop_r   <= 1'b0;
      end else begin
        if (enq_s) enqCnt_r <= enqCnt_r + 32'd1;
        if (setFull_s) full_r <= 1'b1;
        if (setDrop_s) drop_r <= 1'b1;
      end

      if (start_s) begin
        wrAddr_r <= BASE_ADDR;
        len_r    <= 16'h0000;
      end else if (ack_s) begin
        wrAddr_r <= wrAddr_r + 23'd1;
        len_r    <= (len_r == 16'hFFFF) ? len_r : len_r + 16'd1;
      end else begin
        wrAddr_r <= wrAddr_r;
      end

      // A completed transfer always leaves WR_REQ low for at least one cycle.
      if (ack_s) begin
        wrReq_r <= 1'b0;
      end else if (load_s) begin
        wrReq_r  <= 1'b1;
        wrData_r <= loadWord_s;
      end else begin
        wrReq_r <= wrReq_r;
      end
    end
  end

  assign WR_REQ    = wrReq_r;
  assign WR_ADDR   = wrAddr_r;
  assign WR_DATA   = wrData_r;
  assign RECORDING = (state_r != IDLE);
  assign FULL      = full_r;
  assign DROP      = drop_r;
  assign LEN       = len_r;

endmodule
